// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: word-addressed RAM with fixed read/write wait states.
// Define SLC3_MEM_PROTO_CHECK_EN to build the Proto_Err strobe-protocol checker.
module slc3_mem_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  output logic [15:0] Data_to_CPU,
  output logic        Rd_Valid,
  output logic        Wr_Done,
  output logic        Proto_Err
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_HOLD = 3'd2,
    WR_WAIT = 3'd3,
    WR_HOLD = 3'd4
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_done_q, wr_done_d;
  logic              mem_we_c;

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    mem_we_c   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (Mem_OE && !Mem_WE) begin
          addr_d = ADDR;
          if (RD_LAT <= 1) begin
            data_d     = mem[ADDR[ADDR_W-1:0]];
            rd_valid_d = 1'b1;
            state_d    = RD_HOLD;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = RD_WAIT;
          end
        end else if (Mem_WE && !Mem_OE) begin
          addr_d = ADDR;
          if (WR_LAT <= 1) begin
            mem_we_c  = 1'b1;
            wr_done_d = 1'b1;
            state_d   = WR_HOLD;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!Mem_OE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          data_d     = mem[addr_q[ADDR_W-1:0]];
          rd_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = RD_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_HOLD: begin
        if (Mem_OE) rd_valid_d = 1'b1;
        else        state_d    = IDLE;
      end
      WR_WAIT: begin
        if (!Mem_WE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(WR_LAT - 1)) begin
          mem_we_c  = 1'b1;
          wr_done_d = 1'b1;
          cnt_d     = '0;
          state_d   = WR_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_HOLD: begin
        if (Mem_WE) wr_done_d = 1'b1;
        else        state_d   = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
    end
  end

  // RAM is not reset so the program image survives a CPU reset
  always_ff @(posedge Clk) begin
    if (!Reset && mem_we_c) mem[ADDR[ADDR_W-1:0]] <= Data_from_CPU;
  end

  assign Data_to_CPU = data_q;
  assign Rd_Valid    = rd_valid_q;
  assign Wr_Done     = wr_done_q;

`ifdef SLC3_MEM_PROTO_CHECK_EN
  logic proto_err_q;
  logic oe_prev_q, we_prev_q;
  logic err_c;

  // Strobe-protocol violations, evaluated against the current state
  always_comb begin
    err_c = 1'b0;
    case (state_q)
      IDLE:    err_c = Mem_OE && Mem_WE;
      RD_WAIT: err_c = !Mem_OE || (ADDR != addr_q) || (Mem_WE && !we_prev_q);
      RD_HOLD: err_c = (Mem_OE && (ADDR != addr_q)) || (Mem_WE && !we_prev_q);
      WR_WAIT: err_c = !Mem_WE || (ADDR != addr_q) || (Mem_OE && !oe_prev_q);
      WR_HOLD: err_c = Mem_OE && !oe_prev_q;
      default: err_c = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      proto_err_q <= 1'b0;
      oe_prev_q   <= 1'b0;
      we_prev_q   <= 1'b0;
    end else begin
      proto_err_q <= err_c;
      oe_prev_q   <= Mem_OE;
      we_prev_q   <= Mem_WE;
    end
  end

  assign Proto_Err = proto_err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[15:ADDR_W];
  assign Proto_Err      = 1'b0;
`endif

endmodule

// File: doc/slc3_mem_responder.md
# slc3_mem_responder

Memory-side responder for the SLC-3 control path: answers the Mem_OE/Mem_WE strobes issued by the instruction sequencer with a word-addressed synchronous RAM model. It has a fixed, parameterised wait-state latency, so the sequencer's multi-cycle read and write states see deterministic data timing. It sits between MAR/MDR and the CPU data bus in place of the physical SRAM for simulation and FPGA builds.

## Interface
- ADDR_W, 10: RAM index width; depth = 2**ADDR_W words of 16 bits.
- RD_LAT, 1: cycles from the first sampled Mem_OE to Rd_Valid (minimum 1).
- WR_LAT, 2: consecutive Mem_WE cycles required before the write commits (minimum 1).

- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- ADDR  in  16  word address from MAR; only ADDR[ADDR_W-1:0] is used (aliasing)
- Data_from_CPU  in  16  write data from MDR
- Mem_OE  in  1  read strobe, active-high, held for the whole read
- Mem_WE  in  1  write strobe, active-high, held for the whole write
- Data_to_CPU  out  16  read data, registered
- Rd_Valid  out  1  Data_to_CPU is valid for the current read
- Wr_Done  out  1  current write has committed
- Proto_Err  out  1  single-cycle protocol-violation pulse

## Operation
- FSM states: IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_HOLD. A counter of width clog2(max(RD_LAT, WR_LAT))+1 tracks wait cycles.
- IDLE:
  - Mem_OE=1, Mem_WE=0: latch ADDR. Go to RD_HOLD if RD_LAT=1, else RD_WAIT with cnt=1.
  - Mem_WE=1, Mem_OE=0: go to WR_HOLD with an immediate commit if WR_LAT=1, else WR_WAIT with cnt=1.
  - Both strobes high: no access and the FSM stays in IDLE.
- RD_WAIT: cnt increments. At cnt=RD_LAT-1 the FSM loads Data_to_CPU from mem[latched addr] and enters RD_HOLD.
- RD_HOLD: Rd_Valid=1 and Data_to_CPU holds its value. Mem_OE=0 returns the FSM to IDLE; Data_to_CPU keeps the last value and Rd_Valid drops.
- WR_WAIT: cnt increments. In the cycle where cnt=WR_LAT-1 with Mem_WE still high, the RAM writes mem[ADDR] <= Data_from_CPU at the closing edge and the FSM enters WR_HOLD.
- WR_HOLD: Wr_Done=1 until Mem_WE=0, then IDLE. Exactly one commit happens per strobe assertion.
- Early strobe drop in RD_WAIT or WR_WAIT: abort to IDLE with no RAM write.
- Reset: FSM goes to IDLE, cnt=0 and any pending write is discarded. RAM contents are not cleared, so the program image survives a CPU reset.

## Timing
- Output reset values: Data_to_CPU=0x0000, Rd_Valid=0, Wr_Done=0, Proto_Err=0.
- Read timing, with OE cycles numbered from 1: Rd_Valid and data are present in cycle RD_LAT+1. With the default RD_LAT=1, data is valid in the second OE cycle, in time for an LD_MDR at the end of that cycle.
- Write timing: the RAM updates at the edge ending WE cycle WR_LAT, and Wr_Done rises in cycle WR_LAT+1. The default is a three-cycle WE store with its commit at the end of cycle 2.
- Back-to-back accesses: a strobe seen in the first IDLE cycle after a drop starts a new access. No dead cycle beyond the one IDLE cycle is required.
- Read-after-write to the same address returns the new data.

## Configuration
- SLC3_MEM_PROTO_CHECK_EN defined: Proto_Err pulses for one cycle, registered, on any of:
  - both strobes high in IDLE;
  - a strobe dropped during RD_WAIT or WR_WAIT;
  - ADDR changing during RD_WAIT, RD_HOLD or WR_WAIT;
  - Mem_WE rising during a read, or Mem_OE rising during a write.
- The FSM recovery rules are identical with or without the macro.
- Macro undefined: Proto_Err is tied to 0 and the checking logic is not built.

## Test plan
- Reset, then Mem_OE=1 for 2 cycles at ADDR=0x0005 with mem[5]=0x1234 -> Data_to_CPU=0x1234 and Rd_Valid=1 in cycle 2; Rd_Valid=0 after OE drops.
- Mem_WE=1 for 3 cycles with ADDR=0x0010 and Data_from_CPU=0xBEEF, then a 2-cycle read of 0x0010 -> commit at the end of cycle 2, Wr_Done=1 in cycle 3, read returns 0xBEEF.
- Mem_WE=1 for 1 cycle with ADDR=0x0020 and Data_from_CPU=0xAAAA, where mem[0x20]=0x5555 -> no write; a read returns 0x5555; Proto_Err pulses once (macro on).
- Mem_OE=1 and Mem_WE=1 together -> state stays IDLE, no write, Rd_Valid=0; Proto_Err=1 for one cycle (macro on) or 0 (macro off).
- Reset asserted in the first WE cycle of a write of 0xCAFE to 0x0030 -> mem[0x30] unchanged, all outputs at reset values the next cycle.
- Write 0x7777 to ADDR=0x0401 with ADDR_W=10 -> a read of 0x0001 returns 0x7777 (aliasing).
